lsu_unit: RTL and testbench

Load/store unit between the execute stage and `mem_controller`'s data port. It accepts one RISC-V load or store per handshake and checks alignment. Sub-word stores become read-modify-write sequences, because the memory controller only writes whole words in full-word mode. Load data is returned sign- or zero-extended to the pipeline as a one-cycle response pulse.

---
 rtl/lsu_unit_if.sv | 37 +++
 rtl/lsu_unit.sv | 174 +++++++++++++++++
 tb/tb_lsu_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_unit_if.sv
// Bus bundle for lsu_unit.
//   req_*  : pipeline request (valid/ready handshake)
//   resp_* : one-cycle completion pulse back to the pipeline
//   mem_*  : full-word data port towards mem_controller
// slave  = lsu_unit view, master = pipeline + memory view.
interface lsu_unit_if #(
    parameter int unsigned WORD_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [WORD_WIDTH-1:0] req_addr;
    logic [WORD_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic [WORD_WIDTH-1:0] resp_rdata;
    logic [1:0]            resp_err;

    logic [WORD_WIDTH-1:0] mem_address;
    logic                  mem_we;
    logic [WORD_WIDTH-1:0] mem_wd;
    logic [2:0]            mem_access;
    logic [WORD_WIDTH-1:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_we, mem_wd, mem_access
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_we, mem_wd, mem_access
    );
endinterface

// File: rtl/lsu_unit.sv
// Load/store unit between execute and mem_controller's data port.
// Accepts one RISC-V load/store per handshake, checks alignment and funct3,
// turns SB/SH into read-modify-write of a full word, and returns extended
// load data as a one-cycle response pulse.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : lsu_unit_if.slave (request, response and memory port)
module lsu_unit #(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    lsu_unit_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_LDONE = 3'd2,
        ST_MERGE = 3'd3,
        ST_WR    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_F3    = 2'b10;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  we_q, we_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0] wbuf_q, wbuf_d;
    logic                  ready_q, ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [WORD_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic [1:0]            resp_err_q, resp_err_d;

    // Request classification on the raw request inputs (used at accept).
    logic illegal_c;
    logic misaligned_c;
    always_comb begin
        if (bus.req_we) begin
            illegal_c = bus.req_funct3[2] | (bus.req_funct3[1] & bus.req_funct3[0]);
        end else begin
            illegal_c = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
        end
        misaligned_c = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    end

    // Lane selection from the latched address (little-endian).
    logic [4:0]            byte_pos;
    logic [4:0]            half_pos;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [WORD_WIDTH-1:0] ld_ext;
    logic [WORD_WIDTH-1:0] st_mask;
    logic [WORD_WIDTH-1:0] st_data;
    always_comb begin
        byte_pos = {addr_q[1:0], 3'b000};
        half_pos = {addr_q[1], 4'b0000};
        rd_byte  = bus.mem_rd[byte_pos +: 8];
        rd_half  = bus.mem_rd[half_pos +: 16];
        case (funct3_q)
            3'b000:  ld_ext = {{(WORD_WIDTH-8){rd_byte[7]}}, rd_byte};
            3'b001:  ld_ext = {{(WORD_WIDTH-16){rd_half[15]}}, rd_half};
            3'b100:  ld_ext = WORD_WIDTH'(rd_byte);
            3'b101:  ld_ext = WORD_WIDTH'(rd_half);
            default: ld_ext = bus.mem_rd;
        endcase
        // Half stores are aligned, so the byte shift also positions the half.
        st_mask = (funct3_q[0] ? WORD_WIDTH'(16'hFFFF) : WORD_WIDTH'(8'hFF)) << byte_pos;
        st_data = wdata_q << byte_pos;
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            funct3_q     <= 3'b000;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wbuf_q       <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_OK;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            wbuf_q       <= wbuf_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        wbuf_d       = wbuf_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = ERR_OK;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    addr_d   = bus.req_addr;
                    funct3_d = bus.req_funct3;
                    we_d     = bus.req_we;
                    wdata_d  = bus.req_wdata;
                    if (illegal_c) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = ERR_F3;
                    end else if (misaligned_c) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = ERR_ALIGN;
                    end else if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
                        state_d = ST_WR;
                        wbuf_d  = bus.req_wdata;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                state_d = we_q ? ST_MERGE : ST_LDONE;
            end
            ST_LDONE: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = ld_ext;
                state_d      = ST_IDLE;
            end
            ST_MERGE: begin
                wbuf_d  = (bus.mem_rd & ~st_mask) | (st_data & st_mask);
                state_d = ST_WR;
            end
            ST_WR: begin
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic ready_d_c;
    assign ready_d_c = (state_d == ST_IDLE);
    assign ready_d   = ready_d_c;

    // Gating with rst_n keeps a reset edge from committing a partial RMW.
    assign bus.mem_we      = (state_q == ST_WR) && rst_n;
    assign bus.mem_address = {addr_q[WORD_WIDTH-1:2], 2'b00};
    assign bus.mem_wd      = wbuf_q;
    assign bus.mem_access  = 3'b010;
    assign bus.req_ready   = ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: vector table + scoreboard queue, a
// word-addressed memory model with write-then-read, and a mid-RMW reset.
module tb_lsu_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_unit_if #(.WORD_WIDTH(32)) bus ();

    lsu_unit #(.WORD_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Memory model: write first, then registered read of the same address.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_address[7:2]] = bus.mem_wd;
        bus.mem_rd <= mem[bus.mem_address[7:2]];
    end

    typedef struct {
        string       nm;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        logic        wr;
        logic [31:0] wd;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        logic        wr;
        logic [31:0] wa;
        logic [31:0] wd;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[$];
    int   ntotal = 0;
    int   nbad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic [1:0] err,
                                input int lat, input logic wr, input logic [31:0] wd);
        vec_t v;
        v.nm = nm; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.wr = wr; v.wd = wd;
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the response cycle.
    task automatic run(input vec_t v);
        exp_t        e;
        logic        seen;
        int          wr_cnt;
        int          wr_k;
        logic [31:0] wr_a;
        logic [31:0] wr_d;
        chk({v.nm, " ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = v.we;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        e.rdata = v.rdata; e.err = v.err; e.lat = v.lat; e.wr = v.wr;
        e.wa = {v.addr[31:2], 2'b00}; e.wd = v.wd;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        // Junk request while busy must be ignored.
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_003C;
        bus.req_wdata  = 32'hBAD0_BAD0;
        seen = 1'b0; wr_cnt = 0; wr_k = 0; wr_a = '0; wr_d = '0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                wr_cnt++; wr_k = k; wr_a = bus.mem_address; wr_d = bus.mem_wd;
            end
            if (bus.resp_valid) begin
                seen = 1'b1;
                e = sbq.pop_front();
                chk({v.nm, " rdata"}, bus.resp_rdata, e.rdata);
                chk({v.nm, " err"}, 32'(bus.resp_err), 32'(e.err));
                chk({v.nm, " latency"}, 32'(k), 32'(e.lat));
                chk({v.nm, " writes"}, 32'(wr_cnt), e.wr ? 32'd1 : 32'd0);
                if (e.wr) begin
                    chk({v.nm, " wr_data"}, wr_d, e.wd);
                    chk({v.nm, " wr_addr"}, wr_a, e.wa);
                    chk({v.nm, " wr_cycle"}, 32'(wr_k), 32'(e.lat - 1));
                end
            end
        end
        if (!seen) begin
            ntotal++; nbad++;
            $display("FAIL %s timeout: no resp_valid within 8 cycles, want cycle %0d", v.nm, v.lat);
            void'(sbq.pop_front());
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        vec_t lw;
        int   spur;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        //         name        we   f3      addr          wdata          rdata          err    lat wr   wd
        tbl.push_back(mk("sw10",   1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        2'b00, 2, 1, 32'hDEADBEEF));
        tbl.push_back(mk("lw10",   0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 2'b00, 3, 0, 32'h0));
        tbl.push_back(mk("lb13",   0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 2'b00, 3, 0, 32'h0));
        tbl.push_back(mk("lbu13",  0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 2'b00, 3, 0, 32'h0));
        tbl.push_back(mk("lh12",   0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 2'b00, 3, 0, 32'h0));
        tbl.push_back(mk("lhu10",  0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 2'b00, 3, 0, 32'h0));
        tbl.push_back(mk("sb11",   1, 3'b000, 32'h11, 32'h00000055, 32'h0,        2'b00, 4, 1, 32'hDEAD55EF));
        tbl.push_back(mk("sh12",   1, 3'b001, 32'h12, 32'hAAAA1234, 32'h0,        2'b00, 4, 1, 32'h123455EF));
        tbl.push_back(mk("lw10b",  0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 2'b00, 3, 0, 32'h0));
        tbl.push_back(mk("lb11",   0, 3'b000, 32'h11, 32'h0,        32'h00000055, 2'b00, 3, 0, 32'h0));
        tbl.push_back(mk("lh10",   0, 3'b001, 32'h10, 32'h0,        32'h000055EF, 2'b00, 3, 0, 32'h0));
        tbl.push_back(mk("lb10",   0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF, 2'b00, 3, 0, 32'h0));
        tbl.push_back(mk("sb13",   1, 3'b000, 32'h13, 32'hABCDEFFF, 32'h0,        2'b00, 4, 1, 32'hFF3455EF));
        tbl.push_back(mk("lh12b",  0, 3'b001, 32'h12, 32'h0,        32'hFFFFFF34, 2'b00, 3, 0, 32'h0));
        tbl.push_back(mk("lhu12",  0, 3'b101, 32'h12, 32'h0,        32'h0000FF34, 2'b00, 3, 0, 32'h0));
        tbl.push_back(mk("sb10",   1, 3'b000, 32'h10, 32'h00000080, 32'h0,        2'b00, 4, 1, 32'hFF345580));
        tbl.push_back(mk("lw12e",  0, 3'b010, 32'h12, 32'h0,        32'h0,        2'b01, 1, 0, 32'h0));
        tbl.push_back(mk("ld011",  0, 3'b011, 32'h10, 32'h0,        32'h0,        2'b10, 1, 0, 32'h0));
        tbl.push_back(mk("sh13e",  1, 3'b001, 32'h13, 32'h0,        32'h0,        2'b01, 1, 0, 32'h0));
        tbl.push_back(mk("ld110",  0, 3'b110, 32'h13, 32'h0,        32'h0,        2'b10, 1, 0, 32'h0));
        tbl.push_back(mk("st100",  1, 3'b100, 32'h10, 32'h0,        32'h0,        2'b10, 1, 0, 32'h0));
        tbl.push_back(mk("st011",  1, 3'b011, 32'h10, 32'h0,        32'h0,        2'b10, 1, 0, 32'h0));
        tbl.push_back(mk("lh11e",  0, 3'b001, 32'h11, 32'h0,        32'h0,        2'b01, 1, 0, 32'h0));
        tbl.push_back(mk("sw11e",  1, 3'b010, 32'h11, 32'h0,        32'h0,        2'b01, 1, 0, 32'h0));
        tbl.push_back(mk("lw10c",  0, 3'b010, 32'h10, 32'h0,        32'hFF345580, 2'b00, 3, 0, 32'h0));

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready", 32'(bus.req_ready), 32'd1);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst mem_address", bus.mem_address, 32'h0);
        chk("rst resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst resp_err", 32'(bus.resp_err), 32'd0);
        chk("mem_access", 32'(bus.mem_access), 32'd2);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

        // Reset during the WR cycle of SB 0x10.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h77;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst wr before", 32'(bus.mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst mem_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        chk("midrst ready", 32'(bus.req_ready), 32'd1);
        chk("midrst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("midrst mem_address", bus.mem_address, 32'h0);
        chk("midrst mem word", mem[4], 32'hFF345580);
        rst_n = 1'b1;
        spur = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) spur++;
        end
        chk("midrst no resp", 32'(spur), 32'd0);
        lw = mk("lw10d", 0, 3'b010, 32'h10, 32'h0, 32'hFF345580, 2'b00, 3, 0, 32'h0);
        run(lw);
        chk("sb queue empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", ntotal, nbad);
        $finish;
    end

endmodule
